// File: rtl/edge_tick_pkg.sv
// Shared defaults and the counter-width helper for the edge/tick generator.
package edge_tick_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TICK_PERIOD_MAX = 1000;

  // Bits needed to hold the values 0..n-1, never fewer than one.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/edge_sync_ch.sv
// One input channel: synchroniser, optional debounce filter (EDGE_DEBOUNCE_EN),
// history flop, and rising/falling/sticky edge flags.
module edge_sync_ch
  import edge_tick_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sticky_clr,
  output logic din_sync,
  output logic redge,
  output logic fedge,
  output logic edge_sticky
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("edge_sync_ch: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt;
  logic                   hist_q;
  logic                   rise_nxt;
  logic                   fall_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int DW = clog2w(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt;
  logic          filt_q;

  // The filtered level only follows s after it has disagreed for a full run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      filt_q <= 1'b0;
    end else if (s == filt_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      filt_q <= s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s;
`endif

  assign rise_nxt = filt & ~hist_q;
  assign fall_nxt = ~filt & hist_q;

  // History resets low, so a high input at reset release reports a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q      <= 1'b0;
      din_sync    <= 1'b0;
      redge       <= 1'b0;
      fedge       <= 1'b0;
      edge_sticky <= 1'b0;
    end else begin
      hist_q      <= filt;
      din_sync    <= filt;
      redge       <= rise_nxt;
      fedge       <= fall_nxt;
      edge_sticky <= (edge_sticky & ~sticky_clr) | rise_nxt | fall_nxt;
    end
  end

  edges_exclusive: assert property (@(posedge clk) disable iff (rst) !(redge && fedge));

endmodule

// File: rtl/edge_tick_gen.sv
// Programmable-period tick strobe plus NUM_CH synchronised edge-detect channels.
// Define EDGE_DEBOUNCE_EN to add a per-channel debounce filter.
module edge_tick_gen
  import edge_tick_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int TICK_PERIOD_MAX = DEF_TICK_PERIOD_MAX,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int PW             = clog2w(TICK_PERIOD_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic [PW-1:0]     tick_period,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] sticky_clr,
  output logic              tick,
  output logic [NUM_CH-1:0] din_sync,
  output logic [NUM_CH-1:0] redge,
  output logic [NUM_CH-1:0] fedge,
  output logic [NUM_CH-1:0] edge_sticky
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("edge_tick_gen: NUM_CH must be within 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_tick_gen: SYNC_STAGES must be at least 2");
  end

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] eff_period;
  logic          at_wrap;

  always_comb begin
    eff_period = tick_period;
    if (tick_period == '0) eff_period = PW'(1);
  end

  // Using >= rather than == lets a shortened period wrap at once instead of overrunning.
  assign at_wrap = (cnt_q >= (eff_period - PW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!tick_en) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (at_wrap) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

  period_in_range: assert property (@(posedge clk) disable iff (rst)
    tick_en |-> (tick_period <= PW'(TICK_PERIOD_MAX)));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_sync_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .din        (din[i]),
      .sticky_clr (sticky_clr[i]),
      .din_sync   (din_sync[i]),
      .redge      (redge[i]),
      .fedge      (fedge[i]),
      .edge_sticky(edge_sticky[i])
    );
  end

endmodule

// File: tb/tb_edge_tick_gen.sv
// Scoreboard bench for edge_tick_gen: expected outputs come from a cycle-level
// model of the tick and edge rules; a monitor compares them as cycles complete.
module tb_edge_tick_gen;
  import edge_tick_pkg::*;

  localparam int NUM_CH          = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int TICK_PERIOD_MAX = 1000;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int PW              = clog2w(TICK_PERIOD_MAX + 1);
`ifdef EDGE_DEBOUNCE_EN
  localparam int DB_EXTRA = DEBOUNCE_CYCLES;
`else
  localparam int DB_EXTRA = 0;
`endif

  typedef struct {
    int                tgt;
    logic              tick;
    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] sticky;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick_en = 1'b0;
  logic [PW-1:0]     tick_period = '0;
  logic [NUM_CH-1:0] din = '0;
  logic [NUM_CH-1:0] sticky_clr = '0;
  logic              tick;
  logic [NUM_CH-1:0] din_sync;
  logic [NUM_CH-1:0] redge;
  logic [NUM_CH-1:0] fedge;
  logic [NUM_CH-1:0] edge_sticky;

  int   check_count = 0;
  int   fail_count  = 0;
  int   cyc         = 0;
  exp_t sb[$];

  // Model state: levels seen after the synchroniser/filter, sticky flags, tick phase.
  int                elapsed;
  logic [NUM_CH-1:0] lvl1;
  logic [NUM_CH-1:0] lvl2;
  logic [NUM_CH-1:0] m_sticky;
  logic [NUM_CH-1:0] s_cur;
  logic [NUM_CH-1:0] pipe[$];
`ifdef EDGE_DEBOUNCE_EN
  logic [NUM_CH-1:0] s_prev;
  int                run[NUM_CH];
`endif

  edge_tick_gen #(
    .NUM_CH         (NUM_CH),
    .SYNC_STAGES    (SYNC_STAGES),
    .TICK_PERIOD_MAX(TICK_PERIOD_MAX),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .tick_period(tick_period),
    .din        (din),
    .sticky_clr (sticky_clr),
    .tick       (tick),
    .din_sync   (din_sync),
    .redge      (redge),
    .fedge      (fedge),
    .edge_sticky(edge_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    elapsed  = 0;
    lvl1     = '0;
    lvl2     = '0;
    m_sticky = '0;
    s_cur    = '0;
    pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back('0);
`ifdef EDGE_DEBOUNCE_EN
    s_prev = '0;
    for (int i = 0; i < NUM_CH; i++) run[i] = 0;
`endif
  endtask

  // Drive one cycle of inputs, predict the outputs after the coming edge, then wait it out.
  task automatic applyStimulus(input logic en, input int period, input logic [NUM_CH-1:0] d,
                               input logic [NUM_CH-1:0] clr);
    exp_t              e;
    int                eff;
    logic [NUM_CH-1:0] nl;
    tick_en     = en;
    tick_period = PW'(period);
    din         = d;
    sticky_clr  = clr;

    e.tgt = cyc + 1;
    eff   = (period == 0) ? 1 : period;
    if (!en) begin
      elapsed = 0;
      e.tick  = 1'b0;
    end else begin
      elapsed++;
      e.tick = (elapsed >= eff);
      if (e.tick) elapsed = 0;
    end
    e.sync   = lvl1;
    e.rise   = lvl1 & ~lvl2;
    e.fall   = ~lvl1 & lvl2;
    e.sticky = (m_sticky & ~clr) | e.rise | e.fall;
    m_sticky = e.sticky;

    pipe.push_back(d);
    void'(pipe.pop_front());
`ifdef EDGE_DEBOUNCE_EN
    s_prev = s_cur;
    s_cur  = pipe[0];
    nl     = lvl1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_prev[i] != lvl1[i]) run[i]++;
      else run[i] = 0;
      if (run[i] == DEBOUNCE_CYCLES) begin
        nl[i]  = s_prev[i];
        run[i] = 0;
      end
    end
`else
    s_cur = pipe[0];
    nl    = s_cur;
`endif
    lvl2 = lvl1;
    lvl1 = nl;
    sb.push_back(e);

    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tick"}, 32'(tick), 32'd0);
    checkOutput({tag, "_din_sync"}, 32'(din_sync), 32'd0);
    checkOutput({tag, "_redge"}, 32'(redge), 32'd0);
    checkOutput({tag, "_fedge"}, 32'(fedge), 32'd0);
    checkOutput({tag, "_sticky"}, 32'(edge_sticky), 32'd0);
  endtask

  // Monitor: each completed cycle is compared against the prediction queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0 && sb[0].tgt == cyc) begin
        e = sb.pop_front();
        checkOutput("tick", 32'(tick), 32'(e.tick));
        checkOutput("din_sync", 32'(din_sync), 32'(e.sync));
        checkOutput("redge", 32'(redge), 32'(e.rise));
        checkOutput("fedge", 32'(fedge), 32'(e.fall));
        checkOutput("edge_sticky", 32'(edge_sticky), 32'(e.sticky));
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] d;
    logic [NUM_CH-1:0] c;
    logic              en;
    int                per;

    modelReset();
    din = 4'b1010;
    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();

    $display("[TB] tick period 5 with din=1010 held through reset release");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 5, 4'b1010, '0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1, 4'b1010, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 4'b1010, '0);

    $display("[TB] period lowered from 10 to 4 with count at 7");
    applyStimulus(1'b0, 10, 4'b1010, '0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 10, 4'b1010, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4, 4'b1010, '0);

    $display("[TB] single-channel edges on din[0]");
    for (int i = 0; i < 8 + DB_EXTRA; i++) applyStimulus(1'b0, 1, 4'b0000, '0);
    for (int i = 0; i < 8 + DB_EXTRA; i++) applyStimulus(1'b0, 1, 4'b0001, '0);
    for (int i = 0; i < 8 + DB_EXTRA; i++) applyStimulus(1'b0, 1, 4'b0000, '0);

    $display("[TB] sticky clear coinciding with redge[1], then a lone clear");
    applyStimulus(1'b0, 1, 4'b0010, 4'b1111);
    for (int i = 0; i < SYNC_STAGES - 1 + DB_EXTRA; i++) applyStimulus(1'b0, 1, 4'b0010, '0);
    applyStimulus(1'b0, 1, 4'b0010, 4'b0010);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1, 4'b0010, '0);
    applyStimulus(1'b0, 1, 4'b0010, 4'b0010);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1, 4'b0010, '0);

`ifdef EDGE_DEBOUNCE_EN
    $display("[TB] debounce: short glitch then a held change on din[2]");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1, 4'b0100, '0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1, 4'b0000, '0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1, 4'b0100, '0);
`endif

    $display("[TB] asynchronous reset mid-count");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 7, 4'b1010, 4'b0000);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3, 4'b1010, '0);

    $display("[TB] randomized traffic");
    d   = 4'b1010;
    en  = 1'b1;
    per = 5;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
        c[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 19) == 0) per = $urandom_range(0, 12);
      en = ($urandom_range(0, 19) != 0);
      applyStimulus(en, per, d, c);
    end

    repeat (3) @(posedge clk);
    #4;
    checkOutput("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/edge_tick_gen.md
Name: edge_tick_gen

Overview:
- Parametrised successor to the single-channel pulse/edge block.
- Generates an exact-period tick strobe with a runtime-programmable period and an enable.
- Provides NUM_CH independent synchronised input channels, each with rising, falling and sticky edge flags.
- Sits at the boundary between asynchronous board inputs (buttons, status lines) and synchronous control logic.

Parameters:
- NUM_CH, 4: number of input channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- TICK_PERIOD_MAX, 1000: largest supported tick period in clk cycles. PW = $clog2(TICK_PERIOD_MAX+1).
- DEBOUNCE_CYCLES, 4: stable-cycle count for the debounce filter (>=1). Used only when EDGE_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- tick_en  in  1  tick counter enable.
- tick_period  in  PW  tick period in cycles (0 treated as 1).
- din  in  NUM_CH  raw asynchronous channel inputs.
- sticky_clr  in  NUM_CH  per-channel clear of edge_sticky.
- tick  out  1  one-cycle strobe every tick_period cycles.
- din_sync  out  NUM_CH  synchronised (filtered) level.
- redge  out  NUM_CH  one-cycle rising-edge strobe.
- fedge  out  NUM_CH  one-cycle falling-edge strobe.
- edge_sticky  out  NUM_CH  latched "any edge since last clear".

Interface:
- One clock; reset is asynchronous and active-high.
- All outputs are registered.

Behaviour:
- Reset: tick, din_sync, redge, fedge and edge_sticky are 0; tick counter is 0; all sync/history flops are 0.
- Tick counter cnt (PW bits):
  - If tick_en=0: cnt <= 0, tick <= 0.
  - Otherwise: if cnt >= eff_period-1, then cnt <= 0 and tick <= 1; else cnt <= cnt+1 and tick <= 0. eff_period = max(tick_period,1).
  - First tick asserts eff_period cycles after tick_en rises.
  - Period 1 (or 0): tick held high every cycle.
  - Period lowered below the current cnt: wrap and tick on the next cycle, with no counter overrun.
  - tick_period > TICK_PERIOD_MAX: undefined; flag in an assertion.
- Per channel:
  - din passes through SYNC_STAGES flops to produce s, then one history flop h.
  - din_sync <= s. redge <= s & ~h. fedge <= ~s & h.
  - Latency from a din transition to redge/fedge is SYNC_STAGES+1 clk cycles. Pulse width is exactly 1 cycle.
- Reset release with din=1: a rising edge is reported, because history resets to 0. This is intended.
- Pulses shorter than one clk period may be missed; no stretching is performed.
- edge_sticky[i] <= (edge_sticky[i] & ~sticky_clr[i]) | redge_next[i] | fedge_next[i].
  - Set wins over a simultaneous clear.
- Asserting rst mid-operation clears everything immediately (asynchronous). No tick or edge output on the first cycle after deassertion, other than the din=1 case above.

Optional Feature:
- Macro EDGE_DEBOUNCE_EN.
- When defined:
  - Each channel inserts a filter between s and h. The filtered level f updates to s only after s differs from f for DEBOUNCE_CYCLES consecutive cycles.
  - The per-channel counter is $clog2(DEBOUNCE_CYCLES+1) bits, resets to 0, and clears whenever s==f.
  - Edges and din_sync derive from f. Latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - A glitch shorter than DEBOUNCE_CYCLES produces no edge.
- When undefined: f = s; no counters exist; latency is as stated above.

Decomposition:
- Package edge_tick_pkg:
  - function clog2w(n) for counter widths.
  - Default localparams for SYNC_STAGES, DEBOUNCE_CYCLES and TICK_PERIOD_MAX.
- Sub-module edge_sync_ch:
  - Single channel: sync chain, optional debounce, history flop, redge/fedge/sticky.
  - Instantiated NUM_CH times in a generate loop.
- Tick counter stays in the top module.

Test Plan:
1. Reset, tick_en=1, tick_period=5 → tick high on cycles 5, 10, 15 after enable; low elsewhere. tick_period=1 → tick constant high.
2. Period change mid-count: cnt=7 with period 10; write period 4 → tick on next cycle, then every 4 cycles.
3. din[0] 0→1 at cycle 0 (SYNC_STAGES=2) → redge[0] high on cycle 3 only. din[0] 1→0 → fedge[0] high exactly 3 cycles later. Other channels stay quiet.
4. Sticky edges: edge on ch1; sticky_clr[1] pulsed on the same cycle redge[1] asserts → edge_sticky[1] stays 1. A later clear with no edge → 0.
5. Reset behaviour: din=4'b1010 held through reset release → redge=4'b1010 once. rst asserted mid-count → tick and counters zero asynchronously.
6. EDGE_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle glitch on din[2] → no edge. A 5-cycle level change → redge[2] at SYNC_STAGES+4+1 cycles after the change.
